dmem_lsu: RTL and testbench

Load/store unit for the memory stage. It sits between the XM pipeline registers and the data `memory` instance, and initiates requests on that memory's address/data_in/access_size/rw/enable/busy/data_out interface. It handles byte, half and word loads with sign or zero extension, and does sub-word stores as read-modify-write. It exposes a stall to the pipeline and returns one response per request.

---
 rtl/dmem_lsu_if.sv | 36 +++
 rtl/dmem_lsu.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Pipeline-to-LSU request/response bus plus the LSU-to-data-memory port.
// master: pipeline and memory side; slave: the LSU.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data_out;

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, stall, resp_valid, resp_data, resp_err,
    input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    output mem_busy, mem_data_out
  );

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    output req_ready, stall, resp_valid, resp_data, resp_err,
    output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    input  mem_busy, mem_data_out
  );
endinterface

// File: rtl/dmem_lsu.sv
// Memory-stage load/store unit: sub-word loads with extension, sub-word stores as read-modify-write.
// Define LSU_BOUNDS_CHECK_EN to flag requests outside [base_addr, base_addr+mem_depth) as errors.
module dmem_lsu
`ifdef LSU_BOUNDS_CHECK_EN
#(
  parameter logic [31:0] base_addr = 32'h80020000,
  parameter logic [31:0] mem_depth = 32'h00100000
)
`endif
(
  input logic       clock,
  input logic       reset,
  dmem_lsu_if.slave bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  state_t      state;
  logic        ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic        mem_enable_q;
  logic        mem_rw_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_data_in_q;

  // request fields latched at acceptance
  logic        store_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        size_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;

`ifdef LSU_BOUNDS_CHECK_EN
  logic [2:0]  nbytes;
`endif

  // request legality, evaluated on the live request inputs
  always_comb begin
    size_bad     = (bus.req_size == SZ_BAD);
    misaligned   = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                   ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
    case (bus.req_size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    out_of_range = (bus.req_addr < base_addr) ||
                   ({1'b0, bus.req_addr} >
                    (({1'b0, base_addr} + {1'b0, mem_depth}) - 33'(nbytes)));
`endif
    req_err = size_bad | misaligned | out_of_range;
  end

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // big-endian lane extraction and store-lane merge on the returned word
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = bus.mem_data_out[31:24];
      2'd1:    lane_byte = bus.mem_data_out[23:16];
      2'd2:    lane_byte = bus.mem_data_out[15:8];
      default: lane_byte = bus.mem_data_out[7:0];
    endcase
    lane_half = off_q[1] ? bus.mem_data_out[15:0] : bus.mem_data_out[31:16];

    case (size_q)
      SZ_BYTE: load_ext = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
      SZ_HALF: load_ext = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
      default: load_ext = bus.mem_data_out;
    endcase

    merged = bus.mem_data_out;
    if (size_q == SZ_BYTE) begin
      case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  // control FSM with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 32'h0;
      resp_err_q    <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_rw_q      <= 1'b1;
      mem_address_q <= 32'h0;
      mem_data_in_q <= 32'h0;
      store_q       <= 1'b0;
      size_q        <= SZ_BYTE;
      signed_q      <= 1'b0;
      off_q         <= 2'd0;
      wdata_q       <= 16'h0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            store_q  <= bus.req_store;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            off_q    <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata[15:0];
            ready_q  <= 1'b0;
            if (req_err) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= 32'h0;
            end else begin
              mem_address_q <= {bus.req_addr[31:2], 2'b00};
              mem_enable_q  <= 1'b1;
              if (bus.req_store && (bus.req_size == SZ_WORD)) begin
                state         <= WR;
                mem_rw_q      <= 1'b0;
                mem_data_in_q <= bus.req_wdata;
              end else begin
                state    <= RD;
                mem_rw_q <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (!bus.mem_busy) begin
            state        <= RD_WAIT;
            mem_enable_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (!bus.mem_busy) begin
            if (store_q) begin
              state         <= WR;
              mem_enable_q  <= 1'b1;
              mem_rw_q      <= 1'b0;
              mem_data_in_q <= merged;
            end else begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_data_q  <= load_ext;
            end
          end
        end
        WR: begin
          if (!bus.mem_busy) begin
            state        <= RESP;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'h0;
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          mem_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready       = ready_q;
  assign bus.stall           = (bus.req_valid & ~ready_q) |
                               ((state != IDLE) && (state != RESP));
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_data       = resp_data_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_data_in     = mem_data_in_q;
  assign bus.mem_access_size = 2'b00;
  assign bus.mem_rw          = mem_rw_q;
  assign bus.mem_enable      = mem_enable_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: transaction-level reference model, bench-side data memory, directed + random requests.
module tb_dmem_lsu;

  localparam logic [31:0] BASE  = 32'h80020000;
  localparam logic [31:0] DEPTH = 32'h00100000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_lsu_if bus();
  dmem_lsu dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- bench data memory ----------------
  logic [31:0] emem [logic [31:0]];
  logic [31:0] rdata_q = 32'h0;
  int n_rd = 0, n_wr = 0, n_en = 0;
  assign bus.mem_data_out = rdata_q;

  function automatic logic [31:0] emem_rd(input logic [31:0] a);
    return emem.exists(a) ? emem[a] : 32'h0;
  endfunction

  always @(posedge clock) begin
    if (bus.mem_enable) n_en++;
    if (bus.mem_enable && !bus.mem_busy) begin
      if (bus.mem_rw) begin
        rdata_q <= emem_rd(bus.mem_address);
        n_rd++;
      end else begin
        emem[bus.mem_address] = bus.mem_data_in;
        n_wr++;
      end
    end
  end

  // busy generator: scheduled holds from main, otherwise random when enabled
  int   hold_len = 0, hold_seq = 0;
  logic rand_busy = 1'b0;
  int   seen_seq = 0, hold_left = 0;
  initial bus.mem_busy = 1'b0;
  always @(posedge clock) begin
    #1;
    if (hold_seq != seen_seq) begin
      seen_seq  = hold_seq;
      hold_left = hold_len;
    end
    if (hold_left > 0) begin
      bus.mem_busy = 1'b1;
      hold_left--;
    end else begin
      bus.mem_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  logic        m_ready = 1'b1, m_resp = 1'b0, m_active = 1'b0;
  int          m_rem = 0;
  logic [31:0] exp_data, exp_waddr, exp_new;
  logic        exp_err, exp_store;
  int          exp_rd, exp_wr, rd0, wr0;

  // A request needs 0 (error), 1 (word store), 2 (load) or 3 (sub-word store)
  // memory phases; each phase ends at the first edge that sees mem_busy low.
  always @(posedge clock) begin
    if (reset) begin
      m_ready = 1'b1; m_resp = 1'b0; m_active = 1'b0; m_rem = 0;
    end else if (m_resp) begin
      m_resp = 1'b0; m_ready = 1'b1;
    end else if (m_active) begin
      if (!bus.mem_busy) m_rem--;
      if (m_rem == 0) begin
        m_active = 1'b0; m_resp = 1'b1;
        if (exp_store) ref_mem[exp_waddr] = exp_new;
      end
    end else if (bus.req_valid && m_ready) begin
      logic [31:0] a, w, wd;
      longint unsigned mask;
      int n, sh;
      a  = bus.req_addr;
      wd = bus.req_wdata;
      n  = (bus.req_size == 2'd0) ? 1 : (bus.req_size == 2'd1) ? 2 : 4;
      exp_err = (bus.req_size == 2'd3) || ((a % n) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
      if ((longint'(a) < longint'(BASE)) || (longint'(a) + n > longint'(BASE) + longint'(DEPTH)))
        exp_err = 1'b1;
`endif
      exp_waddr = a & ~32'h3;
      w    = ref_rd(exp_waddr);
      sh   = (4 - int'(a % 4) - n) * 8;
      mask = (64'd1 << (8 * n)) - 1;
      exp_data = 32'h0; exp_store = 1'b0; exp_rd = 0; exp_wr = 0;
      rd0 = n_rd; wr0 = n_wr;
      m_ready = 1'b0;
      if (exp_err) begin
        m_rem = 0;
      end else if (bus.req_store) begin
        exp_store = 1'b1; exp_wr = 1;
        if (n == 4) begin
          m_rem = 1; exp_new = wd;
        end else begin
          m_rem = 3; exp_rd = 1;
          exp_new = 32'((longint'(w) & ~(mask << sh)) | ((longint'(wd) & mask) << sh));
        end
      end else begin
        m_rem = 2; exp_rd = 1;
        exp_data = 32'((longint'(w) >> sh) & mask);
        if (bus.req_signed && n < 4 && exp_data[8*n-1]) exp_data = exp_data | ~32'(mask);
      end
      if (m_rem == 0) m_resp = 1'b1; else m_active = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
      chk("resp_valid", 32'(bus.resp_valid), 32'(m_resp));
      chk("stall", 32'(bus.stall), 32'((bus.req_valid && !m_ready) || m_active));
      if (bus.mem_enable) begin
        chk("mem_address", bus.mem_address, exp_waddr);
        chk("mem_access_size", 32'(bus.mem_access_size), 32'h0);
      end
      if (m_resp) begin
        chk("resp_data", bus.resp_data, exp_data);
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("mem_reads", 32'(n_rd - rd0), 32'(exp_rd));
        chk("mem_writes", 32'(n_wr - wr0), 32'(exp_wr));
        chk("mem_word", emem_rd(exp_waddr), ref_rd(exp_waddr));
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic do_req(input logic early, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output int lat, output logic [31:0] d, output logic e,
                        output int nen, output logic stall_ok);
    int en0;
    logic got;
    if (early) #1;
    else begin @(posedge clock); #2; end
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    if (hold > 0) begin hold_len = hold; hold_seq++; end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clock);
    en0 = n_en;
    #2;
    bus.req_valid = 1'b0; bus.req_store = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_signed = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 0; d = 32'h0; e = 1'b0; stall_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (bus.resp_valid) begin lat = i; d = bus.resp_data; e = bus.resp_err; break; end
      if (!(bus.stall && !bus.req_ready)) stall_ok = 1'b0;
    end
    nen = n_en - en0;
    if (lat == 0) chk("resp_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nen, nrd, nwr;
    logic [31:0] d, w0;
    logic e, sok;

    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      w0 = $urandom;
      emem[BASE + 32'(4 * i)] = w0;
      ref_mem[BASE + 32'(4 * i)] = w0;
    end
    emem[BASE] = 32'h8CA40004;
    ref_mem[BASE] = 32'h8CA40004;

    // reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst_mem_enable", 32'(bus.mem_enable), 32'h0);
    chk("rst_mem_rw", 32'(bus.mem_rw), 32'h1);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_data_in", bus.mem_data_in, 32'h0);
    @(posedge clock); #2;
    reset = 1'b0;
    chk_en = 1'b1;

    // directed loads on 0x8CA40004
    do_req(0, 0, 2'b00, 1, BASE + 1, 32'h0, 0, lat, d, e, nen, sok);
    chk("lb_s_data", d, 32'hFFFFFFA4);
    chk("lb_s_lat", 32'(lat), 32'd3);
    do_req(0, 0, 2'b00, 0, BASE + 1, 32'h0, 0, lat, d, e, nen, sok);
    chk("lbu_data", d, 32'h000000A4);
    do_req(0, 0, 2'b01, 1, BASE + 2, 32'h0, 0, lat, d, e, nen, sok);
    chk("lh2_data", d, 32'h00000004);
    do_req(0, 0, 2'b01, 1, BASE, 32'h0, 0, lat, d, e, nen, sok);
    chk("lh0_data", d, 32'hFFFF8CA4);

    // byte store read-modify-write
    nrd = n_rd; nwr = n_wr;
    do_req(0, 1, 2'b00, 0, BASE + 3, 32'h00000055, 0, lat, d, e, nen, sok);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_err", 32'(e), 32'h0);
    chk("sb_reads", 32'(n_rd - nrd), 32'd1);
    chk("sb_writes", 32'(n_wr - nwr), 32'd1);
    chk("sb_word", emem_rd(BASE), 32'h8CA40055);

    // errors
    do_req(0, 0, 2'b10, 0, BASE + 2, 32'h0, 0, lat, d, e, nen, sok);
    chk("mis_err", 32'(e), 32'h1);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_no_enable", 32'(nen), 32'd0);
    do_req(0, 0, 2'b11, 0, BASE, 32'h0, 0, lat, d, e, nen, sok);
    chk("size3_err", 32'(e), 32'h1);
    chk("size3_lat", 32'(lat), 32'd1);
    chk("size3_no_enable", 32'(nen), 32'd0);

    // word load with three busy cycles in RD
    do_req(0, 0, 2'b10, 0, BASE, 32'h0, 3, lat, d, e, nen, sok);
    chk("busy_lat", 32'(lat), 32'd6);
    chk("busy_data", d, 32'h8CA40055);
    chk("busy_stall", 32'(sok), 32'h1);

    // word store
    do_req(0, 1, 2'b10, 0, BASE + 4, 32'hCAFEF00D, 0, lat, d, e, nen, sok);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_word", emem_rd(BASE + 4), 32'hCAFEF00D);

`ifdef LSU_BOUNDS_CHECK_EN
    do_req(0, 0, 2'b10, 0, 32'h7FFFFFFC, 32'h0, 0, lat, d, e, nen, sok);
    chk("oob_low_err", 32'(e), 32'h1);
    chk("oob_low_lat", 32'(lat), 32'd1);
    do_req(0, 0, 2'b00, 0, BASE + DEPTH, 32'h0, 0, lat, d, e, nen, sok);
    chk("oob_high_err", 32'(e), 32'h1);
    do_req(0, 0, 2'b00, 0, BASE + DEPTH - 1, 32'h0, 0, lat, d, e, nen, sok);
    chk("top_byte_err", 32'(e), 32'h0);
`else
    do_req(0, 0, 2'b10, 0, 32'h7FFFFFFC, 32'h0, 0, lat, d, e, nen, sok);
    chk("nobounds_err", 32'(e), 32'h0);
    chk("nobounds_lat", 32'(lat), 32'd3);
`endif

    // reset while a word store sits in WR
    w0 = emem_rd(BASE + 8);
    @(posedge clock); #2;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = BASE + 8; bus.req_wdata = ~w0;
    hold_len = 6; hold_seq++;
    @(negedge clock);
    @(posedge clock); #2;
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk("wr_enable", 32'(bus.mem_enable), 32'h1);
    chk("wr_rw", 32'(bus.mem_rw), 32'h0);
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_enable", 32'(bus.mem_enable), 32'h0);
    chk("abort_ready", 32'(bus.req_ready), 32'h1);
    chk("abort_resp", 32'(bus.resp_valid), 32'h0);
    chk("abort_no_write", emem_rd(BASE + 8), w0);
    repeat (8) begin
      @(negedge clock);
      chk("abort_no_resp", 32'(bus.resp_valid), 32'h0);
    end

    // randomized traffic with random memory busy
    rand_busy = 1'b1;
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = BASE + 32'($urandom_range(0, 63));
`ifdef LSU_BOUNDS_CHECK_EN
      case ($urandom_range(0, 11))
        0: a = BASE - 32'($urandom_range(1, 4));
        1: a = BASE + DEPTH - 32'($urandom_range(0, 4));
        default: ;
      endcase
`endif
      do_req(1'($urandom_range(0, 1)), 1'($urandom), sz, 1'($urandom), a, $urandom, 0,
             lat, d, e, nen, sok);
    end
    rand_busy = 1'b0;
    repeat (4) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
